jt51_op_wr_sched: RTL and testbench
===================================

Name: jt51_op_wr_sched

Overview:
- Upstream write scheduler for the per-operator register shift stage.
- Accepts CPU address/data writes to the operator register window (0x40–0xFF) and holds each pending write.
- Tracks the 32-slot rotation and, in the single cen window where the target slot enters the shift stage, drives the matching up_*_op strobes and data byte.
- Sits between the CPU bus front-end and the operator CSR shift stage.

Parameters:
- SLOTS, 32, slots in the rotation; counter width is log2(SLOTS).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cen  in  1  clock enable; every state change except reset is qualified by cen
- zero  in  1  rotation sync; when high in a cen cycle, the current slot is 0
- wr  in  1  CPU write strobe, one clk cycle, independent of cen
- a0  in  1  0 = address write, 1 = data write
- din  in  8  CPU byte
- busy  out  1  a write is pending or firing
- dout  out  8  data byte delivered with the strobes
- up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op, up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op  out  1 each  field update strobes

Behaviour:
- Reset (asynchronous, active-high) clears: slot counter, address latch, pending flag, busy, dout, all strobes. Reset mid-operation discards the pending write; no strobe is emitted afterwards.
- Slot counter:
  - cur = zero ? 0 : cnt.
  - On cen: cnt <= cur+1 mod 32.
  - Without cen the counter holds.
- Address write (wr & !a0): addr <= din. Accepted at any time, including while busy.
- Data write (wr & a0):
  - addr < 0x40: ignored; busy unaffected.
  - addr >= 0x40 and !busy: latch tgt = addr[4:0], grp = addr[7:5], dat = din; pending <= 1; busy <= 1 on the next clk edge.
  - addr >= 0x40 and busy: dropped, unless the optional feature is enabled.
- Fire: on a cen edge where pending and the next slot (cur+1 mod 32) == tgt:
  - pending <= 0.
  - Strobes for grp go high and dout <= dat.
  - Strobes stay high for exactly one cen period, so the CSR stage samples them while slot tgt is current.
  - On the following cen edge the strobes go low and busy clears.
- Group decode (grp = addr[7:5]):
  - 2: dt1 + mul
  - 3: tl
  - 4: ks + ar
  - 5: amsen + d1r
  - 6: dt2 + d2r
  - 7: d1l + rr
  - No other strobe combination is ever produced.
- dout holds its last value when no strobe is active.
- Latency from data write to strobe is 1–32 cen periods. A write landing in the same clk as a fire edge sees busy=1.
- wr is sampled every clk, so CPU writes between cen pulses are never lost.

Optional Feature:
- Macro: JT51_WR_QUEUE_EN.
- Defined:
  - Adds a one-entry holding buffer (tgt/grp/dat).
  - A data write while busy and the buffer empty is stored there.
  - On the cen edge that clears the current write, the buffered entry becomes pending; it fires on its own slot match, no earlier than the next cen.
  - busy = pending | firing | buffer full; writes while the buffer is full are dropped.
- Undefined: no buffer; writes while busy are dropped.

Decomposition:
- Package jt51_op_pkg:
  - group code constants: GRP_DT1MUL=2, GRP_TL=3, GRP_KSAR=4, GRP_AMD1R=5, GRP_DT2D2R=6, GRP_D1LRR=7
  - OP_BASE=8'h40
  - slot width constant
  - typedef for the pending write record {tgt, grp, dat}
- Sub-module jt51_slot_cnt: 5-bit rotation counter with zero sync, exporting cur and next.

Test Plan:
- Reset: all outputs 0; release rst, 40 cen with no writes → no strobe, busy=0.
- Write addr 0x45, data 0x3A, zero at slot 0 → up_dt1_op and up_mul_op high for exactly one cen period while cur=5; dout=0x3A; busy low on the next cen.
- Write addr 0x7F, data 0x11 → only up_tl_op fires, at slot 31; then addr 0xE0, data 0xF2 → up_d1l_op and up_rr_op fire at slot 0 after the counter wraps 31→0.
- Write addr 0x20, data 0x55 → no strobe, busy stays 0.
- While busy with addr 0x81, send data 0x99 to addr 0x82:
  - without queue: only slot 1 fires; the second write is dropped.
  - with JT51_WR_QUEUE_EN: slot 1 fires, then slot 2 (dout=0x99).
- Assert rst with a write pending at slot 20, then release → no strobe ever occurs and busy=0.

Source files
------------

// File: rtl/jt51_op_pkg.sv
// jt51_op_pkg: shared constants, pending-write record and group decode for the operator write scheduler
package jt51_op_pkg;
  localparam int SLOTS = 32;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam logic [7:0] OP_BASE = 8'h40;
  localparam logic [2:0] GRP_DT1MUL = 3'd2;
  localparam logic [2:0] GRP_TL = 3'd3;
  localparam logic [2:0] GRP_KSAR = 3'd4;
  localparam logic [2:0] GRP_AMD1R = 3'd5;
  localparam logic [2:0] GRP_DT2D2R = 3'd6;
  localparam logic [2:0] GRP_D1LRR = 3'd7;
  typedef struct packed {
    logic [SLOT_W-1:0] tgt;
    logic [2:0] grp;
    logic [7:0] dat;
  } wr_rec_t;
  // bit order: dt1 mul tl ks amsen dt2 d1l ar d1r d2r rr
  function automatic logic [10:0] grp_dec(input logic [2:0] g);
    return g == GRP_DT1MUL ? 11'h600 :
           g == GRP_TL     ? 11'h100 :
           g == GRP_KSAR   ? 11'h088 :
           g == GRP_AMD1R  ? 11'h044 :
           g == GRP_DT2D2R ? 11'h022 :
           g == GRP_D1LRR  ? 11'h011 : 11'h000;
  endfunction
endpackage

// File: rtl/jt51_slot_cnt.sv
// jt51_slot_cnt: slot rotation counter with zero sync, exporting current and next slot
module jt51_slot_cnt #(
  parameter int SLOTS = 32,
  parameter int W = $clog2(SLOTS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         zero,
  output logic [W-1:0] cur,
  output logic [W-1:0] nxt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cur = zero ? '0 : cnt_q;
    nxt = (cur == W'(SLOTS - 1)) ? '0 : cur + 1'b1;
    cnt_d = cen ? nxt : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/jt51_op_wr_sched.sv
// jt51_op_wr_sched: holds CPU writes to the operator window and strobes them out when their slot comes round
// Define JT51_WR_QUEUE_EN to add a one-entry buffer for a data write arriving while busy.
module jt51_op_wr_sched
  import jt51_op_pkg::*;
#(
  parameter int SLOTS = jt51_op_pkg::SLOTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       busy,
  output logic [7:0] dout,
  output logic       up_dt1_op,
  output logic       up_mul_op,
  output logic       up_tl_op,
  output logic       up_ks_op,
  output logic       up_amsen_op,
  output logic       up_dt2_op,
  output logic       up_d1l_op,
  output logic       up_ar_op,
  output logic       up_d1r_op,
  output logic       up_d2r_op,
  output logic       up_rr_op
);
  logic [SLOT_W-1:0] cur, nxt;
  logic [7:0] addr_q, addr_d, dout_q, dout_d;
  logic [10:0] up_q, up_d;
  logic pend_q, pend_d, firing, fire, wr_dat, unused_cur;
  wr_rec_t rec_q, rec_d, new_rec;
`ifdef JT51_WR_QUEUE_EN
  wr_rec_t buf_q, buf_d;
  logic bufv_q, bufv_d;
`endif
  jt51_slot_cnt #(.SLOTS(SLOTS), .W(SLOT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .zero(zero),
    .cur (cur),
    .nxt (nxt)
  );
  always_comb begin
    unused_cur = ^cur;
    firing = |up_q;
`ifdef JT51_WR_QUEUE_EN
    busy = pend_q | firing | bufv_q;
`else
    busy = pend_q | firing;
`endif
    wr_dat = wr & a0 & (addr_q >= OP_BASE);
    new_rec = '{tgt: addr_q[SLOT_W-1:0], grp: addr_q[7:5], dat: din};
    // fire one cen early so the strobes are live while slot tgt is current
    fire = cen & pend_q & (nxt == rec_q.tgt);
    addr_d = (wr & ~a0) ? din : addr_q;
    rec_d = rec_q;
    pend_d = pend_q;
    up_d = (cen & firing) ? 11'h000 : up_q;
    dout_d = dout_q;
    if (fire) begin
      pend_d = 1'b0;
      up_d = grp_dec(rec_q.grp);
      dout_d = rec_q.dat;
    end
    if (wr_dat & ~busy) begin
      rec_d = new_rec;
      pend_d = 1'b1;
    end
`ifdef JT51_WR_QUEUE_EN
    buf_d = buf_q;
    bufv_d = bufv_q;
    if (cen & firing & bufv_q) begin
      rec_d = buf_q;
      pend_d = 1'b1;
      bufv_d = 1'b0;
    end
    if (wr_dat & busy & ~bufv_q) begin
      buf_d = new_rec;
      bufv_d = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      rec_q <= '0;
      pend_q <= 1'b0;
      up_q <= '0;
      dout_q <= '0;
    end else begin
      addr_q <= addr_d;
      rec_q <= rec_d;
      pend_q <= pend_d;
      up_q <= up_d;
      dout_q <= dout_d;
    end
`ifdef JT51_WR_QUEUE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buf_q <= '0;
      bufv_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      bufv_q <= bufv_d;
    end
`endif
  assign dout = dout_q;
  assign {up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op,
          up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op} = up_q;
endmodule

// File: tb/tb_jt51_op_wr_sched.sv
// tb_jt51_op_wr_sched: directed checks of slot-timed strobe delivery, group decode, drops and reset
module tb_jt51_op_wr_sched;
  logic clk = 1'b0, rst = 1'b1, cen = 1'b0, zero = 1'b0, wr = 1'b0, a0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic busy;
  logic [7:0] dout;
  logic up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op;
  logic up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op;
  logic [10:0] strb;
  int slot = 0;
  int n_chk = 0, n_fail = 0;

  jt51_op_wr_sched dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .wr(wr), .a0(a0), .din(din),
    .busy(busy), .dout(dout),
    .up_dt1_op(up_dt1_op), .up_mul_op(up_mul_op), .up_tl_op(up_tl_op), .up_ks_op(up_ks_op),
    .up_amsen_op(up_amsen_op), .up_dt2_op(up_dt2_op), .up_d1l_op(up_d1l_op), .up_ar_op(up_ar_op),
    .up_d1r_op(up_d1r_op), .up_d2r_op(up_d2r_op), .up_rr_op(up_rr_op)
  );

  always #5 clk = ~clk;
  assign strb = {up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op,
                 up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1(input logic c);
    cen = c;
    zero = c && (slot == 0);
    @(posedge clk);
    #1;
    if (c) slot = (slot + 1) % 32;
    cen = 1'b0;
    zero = 1'b0;
  endtask

  task automatic wr_byte(input logic a, input logic [7:0] d);
    wr = 1'b1;
    a0 = a;
    din = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clk1(1'b1);
      chk("idle_strb", 16'(strb), 16'h0);
      chk("idle_busy", 16'(busy), 16'h0);
      clk1(1'b0);
    end
  endtask

  task automatic fire_wait(input int tgt, input logic [10:0] es, input logic [7:0] ed, input logic eb);
    int n;
    clk1(1'b1);
    n = 1;
    while (strb == 11'h0 && n < 40) begin
      clk1(1'b0);
      clk1(1'b1);
      n++;
    end
    chk("fire_strb", 16'(strb), 16'(es));
    chk("fire_slot", 16'(slot), 16'(tgt));
    chk("fire_dout", 16'(dout), 16'(ed));
    clk1(1'b0);
    chk("hold_strb", 16'(strb), 16'(es));
    clk1(1'b1);
    chk("clr_strb", 16'(strb), 16'h0);
    chk("clr_busy", 16'(busy), 16'(eb));
    chk("hold_dout", 16'(dout), 16'(ed));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_dout", 16'(dout), 16'h0);
    chk("rst_strb", 16'(strb), 16'h0);
    rst = 1'b0;
    idle(40);
    // addr 0x45 -> slot 5, dt1+mul
    wr_byte(1'b0, 8'h45);
    wr_byte(1'b1, 8'h3A);
    chk("busy_45", 16'(busy), 16'h1);
    fire_wait(5, 11'h600, 8'h3A, 1'b0);
    // addr 0x7F -> slot 31, tl only
    wr_byte(1'b0, 8'h7F);
    wr_byte(1'b1, 8'h11);
    fire_wait(31, 11'h100, 8'h11, 1'b0);
    // addr 0xE0 -> slot 0 across the wrap, d1l+rr
    wr_byte(1'b0, 8'hE0);
    wr_byte(1'b1, 8'hF2);
    chk("busy_E0", 16'(busy), 16'h1);
    fire_wait(0, 11'h011, 8'hF2, 1'b0);
    // below the operator window: ignored
    wr_byte(1'b0, 8'h20);
    wr_byte(1'b1, 8'h55);
    chk("busy_20", 16'(busy), 16'h0);
    idle(40);
    chk("dout_20", 16'(dout), 16'hF2);
    // second write while busy
    wr_byte(1'b0, 8'h81);
    wr_byte(1'b1, 8'h5C);
    chk("busy_81", 16'(busy), 16'h1);
    wr_byte(1'b0, 8'h82);
    wr_byte(1'b1, 8'h99);
`ifdef JT51_WR_QUEUE_EN
    fire_wait(1, 11'h088, 8'h5C, 1'b1);
    fire_wait(2, 11'h088, 8'h99, 1'b0);
`else
    fire_wait(1, 11'h088, 8'h5C, 1'b0);
    idle(40);
    chk("drop_dout", 16'(dout), 16'h5C);
`endif
    // reset with slot 20 pending
    for (int i = 0; i < 32 && slot != 5; i++) clk1(1'b1);
    chk("pre_rst_slot", 16'(slot), 16'h5);
    wr_byte(1'b0, 8'h54);
    wr_byte(1'b1, 8'h66);
    chk("busy_54", 16'(busy), 16'h1);
    clk1(1'b1);
    chk("pre_rst_strb", 16'(strb), 16'h0);
    rst = 1'b1;
    #1;
    chk("arst_busy", 16'(busy), 16'h0);
    chk("arst_dout", 16'(dout), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    slot = 0;
    idle(40);
    chk("post_rst_dout", 16'(dout), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
